// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX/MEM pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [2:0] result_src;
        logic [2:0] funct3;
        logic       reg_write;
        logic       mem_write;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [31:0] ext_imm;
        logic [31:0] pc_imm;
        logic [4:0]  rd;
    } exmem_data_t;

    localparam int CTRL_W_DEF = $bits(exmem_ctrl_t);
    localparam int DATA_W_DEF = $bits(exmem_data_t);
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with optional two-entry skid buffer,
// flush-to-bubble and a back-pressure stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_accept;
    logic              w_pop;
    logic              w_out_valid;
    logic [CTRL_W-1:0] w_head_ctrl;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = w_out_valid & out_ready;

    if (SKID != 0) begin : g_skid
        pipe_state_e       r_state;
        pipe_state_e       w_state_nxt;
        logic [CTRL_W-1:0] r_main_ctrl;
        logic [CTRL_W-1:0] r_skid_ctrl;
        logic [DATA_W-1:0] r_main_data;
        logic [DATA_W-1:0] r_skid_data;
        logic              w_load_main_in;
        logic              w_load_main_skid;
        logic              w_load_skid;

        always_ff @(posedge CLK) begin
            if (!RST_N) r_state <= EMPTY;
            else        r_state <= w_state_nxt;
        end

        always_comb begin
            w_state_nxt = r_state;
            if (flush) begin
                w_state_nxt = EMPTY;
            end else begin
                case (r_state)
                    EMPTY:     if (w_accept) w_state_nxt = FULL;
                    FULL: begin
                        if (w_accept && !w_pop)      w_state_nxt = SKID_FULL;
                        else if (!w_accept && w_pop) w_state_nxt = EMPTY;
                    end
                    SKID_FULL: if (w_pop) w_state_nxt = FULL;
                    default:   w_state_nxt = EMPTY;
                endcase
            end
        end

        // Handshake outputs come from the state register only, so in_ready
        // never depends combinationally on out_ready.
        always_comb begin
            in_ready    = (r_state != SKID_FULL);
            w_out_valid = (r_state != EMPTY);
        end

        assign w_load_main_in   = !flush && w_accept && ((r_state == EMPTY) || w_pop);
        assign w_load_main_skid = !flush && (r_state == SKID_FULL) && w_pop;
        assign w_load_skid      = !flush && (r_state == FULL) && w_accept && !w_pop;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_main_ctrl <= '0;
                r_main_data <= '0;
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
            end else begin
                if (w_load_main_in) begin
                    r_main_ctrl <= in_ctrl;
                    r_main_data <= in_data;
                end else if (w_load_main_skid) begin
                    r_main_ctrl <= r_skid_ctrl;
                    r_main_data <= r_skid_data;
                end
                if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end
        end

        assign w_head_ctrl = r_main_ctrl;
        assign out_data    = r_main_data;
    end else begin : g_single
        logic              r_vld;
        logic [CTRL_W-1:0] r_ctrl;
        logic [DATA_W-1:0] r_data;

        assign in_ready    = !r_vld || out_ready;
        assign w_out_valid = r_vld;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_vld  <= 1'b0;
                r_ctrl <= '0;
                r_data <= '0;
            end else if (flush) begin
                r_vld <= 1'b0;
            end else if (w_accept) begin
                r_vld  <= 1'b1;
                r_ctrl <= in_ctrl;
                r_data <= in_data;
            end else if (w_pop) begin
                r_vld <= 1'b0;
            end
        end

        assign w_head_ctrl = r_ctrl;
        assign out_data    = r_data;
    end

    // Bubbles must never carry reg_write/mem_write downstream.
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? w_head_ctrl : '0;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_inc   (w_out_valid & ~out_ready),
        .o_cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=1 instance (4-bit stall counter) and SKID=0 instance.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = CTRL_W_DEF;
    localparam int DW = DATA_W_DEF;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_stall;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_stall;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .stall_cnt(b_stall)
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        a_in_valid = v; a_in_ctrl = c; a_in_data = d;
    endtask

    task automatic b_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        b_in_valid = v; b_in_ctrl = c; b_in_data = d;
    endtask

    task automatic a_push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        qa.push_back('{c: c, d: d});
    endtask

    task automatic b_push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        qb.push_back('{c: c, d: d});
    endtask

    // Monitor: every pop is checked against the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got data %0h, expected no output", a_out_data);
            end else begin
                e = qa.pop_front();
                chk("a_data", a_out_data, e.d);
                chk("a_ctrl", a_out_ctrl, e.c);
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got data %0h, expected no output", b_out_data);
            end else begin
                e = qb.pop_front();
                chk("b_data", b_out_data, e.d);
                chk("b_ctrl", b_out_ctrl, e.c);
            end
        end
        if (a_out_valid === 1'b0) chk("a_bubble_ctrl", a_out_ctrl, 0);
        if (b_out_valid === 1'b0) chk("b_bubble_ctrl", b_out_ctrl, 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with junk offered on both instances
        rst_n = 1'b0;
        a_drive(1'b1, 8'hFF, '1); a_flush = 1'b0; a_out_ready = 1'b0;
        b_drive(1'b1, 8'hFF, '1); b_flush = 1'b0; b_out_ready = 1'b0;
        repeat (2) tick();
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_ctrl", a_out_ctrl, 0);
        chk("a_rst_stall", a_stall, 0);
        chk("a_rst_ready", a_in_ready, 1);
        chk("a_rst_data", a_out_data, 0);
        chk("b_rst_valid", b_out_valid, 0);
        chk("b_rst_ready", b_in_ready, 1);
        chk("b_rst_data", b_out_data, 0);
        rst_n = 1'b1;
        a_drive(1'b0, '0, '0); b_drive(1'b0, '0, '0);
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        tick();

        // Streaming, no back-pressure
        for (int i = 0; i < 10; i++) begin
            a_drive(1'b1, CW'(8'h80 + i), DW'(i));
            chk("a_stream_ready", a_in_ready, 1);
            a_push(CW'(8'h80 + i), DW'(i));
            tick();
            chk("a_stream_valid", a_out_valid, 1);
        end
        a_drive(1'b0, '0, '0);
        tick();
        chk("a_stream_idle", a_out_valid, 0);
        chk("a_stream_stall", a_stall, 0);

        // Back-pressure: A held, B into skid, C waits
        a_drive(1'b1, 8'hC1, 'h11); a_push(8'hC1, 'h11); tick();
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'hC2, 'h22);
        chk("a_bp_ready_full", a_in_ready, 1);
        a_push(8'hC2, 'h22); tick();
        a_drive(1'b1, 8'hC3, 'h33);
        repeat (2) begin
            chk("a_bp_ready_low", a_in_ready, 0);
            chk("a_bp_head", a_out_data, 'h11);
            tick();
        end
        chk("a_bp_ready_low", a_in_ready, 0);
        chk("a_bp_stall", a_stall, 3);
        a_out_ready = 1'b1;
        tick();
        chk("a_bp_ready_back", a_in_ready, 1);
        a_push(8'hC3, 'h33); tick();
        a_drive(1'b0, '0, '0);
        tick();
        chk("a_bp_drained", a_out_valid, 0);
        chk("a_bp_stall_end", a_stall, 3);

        // Flush in SKID_FULL with an entry offered
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'h0F, 'h55); a_push(8'h0F, 'h55); tick();
        a_drive(1'b1, 8'hF0, 'h66); a_push(8'hF0, 'h66); tick();
        chk("a_fl_skidfull", a_in_ready, 0);
        a_flush = 1'b1;
        a_drive(1'b1, 8'hFF, 'h44);
        tick();
        qa.delete();
        a_flush = 1'b0;
        a_drive(1'b0, '0, '0);
        chk("a_fl_valid", a_out_valid, 0);
        chk("a_fl_ctrl", a_out_ctrl, 0);
        chk("a_fl_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
        repeat (3) tick();
        chk("a_fl_stall", a_stall, 5);
        a_drive(1'b1, 8'h3C, 'h77); a_push(8'h3C, 'h77); tick();
        chk("a_fl_resume", a_out_valid, 1);
        a_drive(1'b0, '0, '0);
        tick();

        // Stall counter saturation (4 bits)
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'h81, 'h88); a_push(8'h81, 'h88); tick();
        a_drive(1'b0, '0, '0);
        repeat (20) tick();
        chk("a_sat_stall", a_stall, 15);
        a_out_ready = 1'b1;
        tick();
        chk("a_sat_drained", a_out_valid, 0);
        chk("a_sat_hold", a_stall, 15);

        // Reset mid-transfer discards held entries
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'h42, 'h99); tick();
        a_drive(1'b1, 8'h43, 'hAA); tick();
        rst_n = 1'b0;
        tick();
        chk("a_mrst_valid", a_out_valid, 0);
        chk("a_mrst_stall", a_stall, 0);
        chk("a_mrst_ready", a_in_ready, 1);
        chk("a_mrst_data", a_out_data, 0);
        rst_n = 1'b1;
        a_drive(1'b0, '0, '0);
        a_out_ready = 1'b1;
        tick();

        // SKID=0: combinational in_ready, one-cycle replace
        b_out_ready = 1'b1;
        b_drive(1'b1, 8'h5A, 'h99);
        chk("b_ready_empty", b_in_ready, 1);
        b_push(8'h5A, 'h99); tick();
        b_drive(1'b0, '0, '0);
        b_out_ready = 1'b0;
        #1;
        chk("b_ready_comb", b_in_ready, 0);
        chk("b_held", b_out_valid, 1);
        tick();
        b_out_ready = 1'b1;
        b_drive(1'b1, 8'hA5, 'hAA);
        #1;
        chk("b_ready_pop", b_in_ready, 1);
        b_push(8'hA5, 'hAA); tick();
        chk("b_replace_valid", b_out_valid, 1);
        chk("b_replace_data", b_out_data, 'hAA);
        b_drive(1'b0, '0, '0);
        tick();
        chk("b_idle", b_out_valid, 0);
        chk("b_stall", b_stall, 1);

        // SKID=0 flush drops held and offered entries
        b_out_ready = 1'b0;
        b_drive(1'b1, 8'h11, 'hBB); tick();
        b_flush = 1'b1;
        b_drive(1'b1, 8'h22, 'hCC); tick();
        b_flush = 1'b0;
        b_drive(1'b0, '0, '0);
        chk("b_fl_valid", b_out_valid, 0);
        b_out_ready = 1'b1;
        repeat (2) tick();
        chk("b_fl_stall", b_stall, 2);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
